// File: rtl/imem_loader_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_responder_if
// Description : Bundle of the fetch-side read port and the program-load byte
//               stream for imem_loader_responder.
//                 pc / instruction_code / stall        - fetch stage
//                 load_valid / load_byte / load_last /
//                 load_ready                           - byte loader
//                 loaded_words / overflow / load_error - load status
//               master : fetch stage + loader (drives pc and the byte stream)
//               slave  : the instruction-memory responder
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_responder_if #(
    parameter int ADDR_W = 8
);
    logic [31:0]     pc;
    logic [31:0]     instruction_code;
    logic            stall;
    logic            load_valid;
    logic [7:0]      load_byte;
    logic            load_last;
    logic            load_ready;
    logic [ADDR_W:0] loaded_words;
    logic            overflow;
    logic            load_error;

    modport master (
        output pc, load_valid, load_byte, load_last,
        input  instruction_code, stall, load_ready, loaded_words, overflow, load_error
    );

    modport slave (
        input  pc, load_valid, load_byte, load_last,
        output instruction_code, stall, load_ready, loaded_words, overflow, load_error
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader_responder.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_responder
// Description : Instruction memory behind the fetch stage. After reset it
//               accepts a little-endian program byte stream, packs it into
//               32-bit words and writes them to an internal array while fetch
//               is stalled. After the byte flagged load_last it releases the
//               stall and serves array[pc/4] combinationally (NOP outside the
//               loaded region or for misaligned pc).
// Ports       : clk   - system clock, rising edge
//               reset - asynchronous, active-low
//               bus   - imem_loader_responder_if.slave (fetch + load stream)
// Options     : IMEM_CHECKSUM_EN - when defined, the word completed by
//               load_last is a checksum compared against the modulo-2^32 sum
//               of all data words; a mismatch parks the block in ERR.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader_responder #(
    parameter int ADDR_W = 8
) (
    input  wire logic              clk,
    input  wire logic              reset,
    imem_loader_responder_if.slave bus
);
    localparam int              DEPTH  = 2 ** ADDR_W;
    localparam logic [31:0]     c_NOP  = 32'h0000_0013;
    localparam logic [ADDR_W:0] c_FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t          r_state;
    logic [1:0]      r_lane;
    logic [23:0]     r_partial;     // lower three bytes of the word in flight
    logic [ADDR_W:0] r_count;
    logic            r_overflow;
    logic            r_stall;
    logic            r_load_ready;
    logic [31:0]     r_mem [DEPTH];

    logic            w_accept;
    logic            w_complete;
    logic            w_data_word;
    logic            w_full;
    logic            w_we;
    logic [31:0]     w_word;

    assign w_accept   = bus.load_valid & r_load_ready;
    // r_partial only ever holds bytes below the current lane, so OR-ing the
    // new byte into its lane yields the word with all upper bytes zero.
    assign w_word     = {8'd0, r_partial} | ({24'd0, bus.load_byte} << {r_lane, 3'b000});
    assign w_complete = w_accept & ((r_lane == 2'd3) | bus.load_last);
`ifdef IMEM_CHECKSUM_EN
    assign w_data_word = w_complete & ~bus.load_last;
`else
    assign w_data_word = w_complete;
`endif
    assign w_full = (r_count == c_FULL);
    assign w_we   = w_data_word & ~w_full;

`ifdef IMEM_CHECKSUM_EN
    logic [31:0] r_csum;
    logic        r_load_error;

    // Dropped overflow words still contribute, so the checksum covers the
    // whole stream the loader sent, not only what fitted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_csum <= '0;
        end else if (w_data_word) begin
            r_csum <= r_csum + w_word;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_LOAD;
            r_lane       <= 2'd0;
            r_partial    <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_stall      <= 1'b1;
            r_load_ready <= 1'b1;
`ifdef IMEM_CHECKSUM_EN
            r_load_error <= 1'b0;
`endif
        end else if (w_accept) begin
            r_partial <= w_complete ? 24'd0 : w_word[23:0];
            r_lane    <= bus.load_last ? 2'd0 : r_lane + 2'd1;

            if (w_data_word) begin
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end

            if (bus.load_last) begin
                r_load_ready <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
                if (w_word == r_csum) begin
                    r_state <= ST_RUN;
                    r_stall <= 1'b0;
                end else begin
                    r_state      <= ST_ERR;
                    r_stall      <= 1'b1;
                    r_load_error <= 1'b1;
                end
`else
                r_state <= ST_RUN;
                r_stall <= 1'b0;
`endif
            end
        end
    end

    // Array is deliberately not reset; r_count gates every read instead.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_count[ADDR_W-1:0]] <= w_word;
        end
    end

    logic [ADDR_W-1:0] w_ridx;
    logic              w_rhit;

    assign w_ridx = bus.pc[ADDR_W+1:2];
    assign w_rhit = (bus.pc[1:0] == 2'b00) &&
                    (bus.pc[31:ADDR_W+2] == '0) &&
                    ({1'b0, w_ridx} < r_count);

    assign bus.instruction_code = w_rhit ? r_mem[w_ridx] : c_NOP;
    assign bus.stall            = r_stall;
    assign bus.load_ready       = r_load_ready;
    assign bus.loaded_words     = r_count;
    assign bus.overflow         = r_overflow;
`ifdef IMEM_CHECKSUM_EN
    assign bus.load_error       = r_load_error;
`else
    assign bus.load_error       = 1'b0;
`endif

    // r_state is only observed through the registered outputs; keep it live.
    logic w_unused;
    assign w_unused = (r_state == ST_ERR);

endmodule
`default_nettype wire

// File: doc/imem_loader_responder.md
# imem_loader_responder

Instruction-memory responder serving the fetch stage. After reset it accepts a program as a little-endian byte stream, packs the bytes into 32-bit words and writes them to an internal word array while holding fetch stalled. Once loading completes it releases the stall and returns the instruction word at the fetch PC combinationally every cycle. It replaces the bare instruction memory behind the fetch stage and is the only path by which program code enters the core.

## Interface
- DEPTH, 256, number of 32-bit instruction words stored
- ADDR_W, 8, word-address width; DEPTH = 2**ADDR_W
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- pc  input  32  byte address from fetch stage
- instruction_code  output  32  instruction word at pc, combinational
- stall  output  1  holds fetch PC; high during loading and on error
- load_valid  input  1  load_byte is valid this cycle
- load_byte  input  8  program byte, little-endian within each word
- load_last  input  1  qualifies final byte of the stream
- load_ready  output  1  block accepts a byte this cycle
- loaded_words  output  ADDR_W+1  count of words written to the array
- overflow  output  1  sticky; a word arrived with the array full
- load_error  output  1  sticky checksum failure (constant 0 without the macro)

## Operation
- States: LOAD, RUN, ERR. Reset enters LOAD.
- Byte accepted when load_valid && load_ready. load_ready = 1 only in LOAD.
- 2-bit lane counter selects the destination byte: lane 0 -> bits [7:0], ..., lane 3 -> bits [31:24]. It increments per accepted byte and wraps 3 -> 0.
- Word completes when lane 3 is accepted, or when a byte with load_last is accepted at any lane. On load_last at lane < 3, the remaining upper bytes are zero.
- A completed data word is written at index loaded_words, and loaded_words increments.
- If loaded_words == DEPTH, the word is dropped, overflow is set, and the count saturates.
- Accepted byte with load_last: transition to RUN, or to ERR with checksum enabled. The lane counter clears.
- RUN: load_valid is ignored. Only reset re-enters LOAD.
- ERR: stall = 1 and load_error = 1 until reset.
- Read, all states:
  - instruction_code = array[pc[ADDR_W+1:2]] when pc[1:0] == 0, pc[31:ADDR_W+2] == 0 and pc[ADDR_W+1:2] < loaded_words.
  - Otherwise instruction_code = 32'h00000013 (NOP).
- Array contents are not cleared by reset. The loaded_words bound makes reads deterministic.

## Timing
- Reset values:
  - Outputs: stall = 1, load_ready = 1, loaded_words = 0, overflow = 0, load_error = 0, instruction_code = 32'h00000013.
  - Internal: lane = 0, partial word = 0, checksum accumulator = 0.
- Array write and loaded_words increment occur on the same edge that accepts the completing byte. The word is readable immediately after that edge.
- stall = (state != RUN). It falls on the edge that accepts load_last, so fetch advances from PC 0 on the next edge.
- load_ready falls on the same edge. No byte is accepted after load_last.
- Read latency: zero cycles, purely combinational from pc and the array.
- Reset asserted mid-load: returns to LOAD with count 0. The partial word is discarded.

## Configuration
- IMEM_CHECKSUM_EN defined:
  - The word completed by load_last is a checksum, not written to the array and not counted.
  - Every data word, including dropped overflow words, is added into a 32-bit accumulator, modulo 2^32.
  - On load_last: checksum == accumulator -> RUN; mismatch -> ERR.
- IMEM_CHECKSUM_EN undefined:
  - The load_last word is ordinary data, written and counted.
  - The block always goes to RUN, and load_error is tied to 0.

## Test plan
- Reset, stream bytes 13 00 00 00 93 00 10 00 with load_last on the 8th (macro off):
  - array[0] = 32'h00000013, array[1] = 32'h00100093, loaded_words = 2.
  - stall falls on the 8th accept edge.
  - pc = 4 returns 32'h00100093; pc = 8 returns NOP.
- Byte 37 with load_last at lane 0 (macro off) -> word 32'h00000037 written, loaded_words = 1, RUN.
- DEPTH = 4, stream 5 words -> overflow = 1, loaded_words = 4, the 5th word is unreadable.
- Macro on, words 32'h00000013, 32'h00100093, then checksum 32'h001000A6 -> RUN, loaded_words = 2. Checksum 32'h001000A7 instead -> ERR, stall = 1, load_error = 1.
- Reset pulsed after 3 bytes -> loaded_words = 0, lane = 0, stall = 1. A fresh 4-byte load then writes array[0] correctly.
- In RUN, pc = 2 and pc = 32'h00001000 -> NOP. load_valid pulses leave loaded_words unchanged.
